layer_mixer: RTL and testbench

Parametrised, pipelined pixel compositor that sits between the per-layer pixel generators (background test card, sprite compositors) and the video output stage. Merges N sprite layers over a background with fixed priority. Adds per-layer enable and 50 % blend modes, both shadow-registered so they change only at frame boundaries. Also reports per-layer collisions (overlap) once per frame.

---
 rtl/layer_mixer_if.sv | 43 ++++
 rtl/layer_mixer.sv | 132 +++++++++++++
 tb/tb_layer_mixer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/layer_mixer_if.sv
// rtl/layer_mixer_if.sv - pixel/config/result bundle for the layer mixer
// Ports (master = pixel source side, slave = mixer side):
//   i_x/i_y/i_de/i_v_sync   pixel timing and coordinates
//   i_bg_rgb/i_layer_rgb    background and per-layer colours {r,g,b}
//   i_layer_hit             per-layer coverage of the current pixel
//   i_cfg_enable/i_cfg_blend requested layer enables / 50% blends
//   o_red/o_green/o_blue    composited pixel, o_x/o_y/o_de/o_v_sync aligned
//   o_collision             per-layer overlap flags for the previous frame
interface layer_mixer_if #(
  parameter int N_LAYERS = 4,
  parameter int CW       = 8,
  parameter int COORD_W  = 16
);
  logic [COORD_W-1:0]        i_x;
  logic [COORD_W-1:0]        i_y;
  logic                      i_de;
  logic                      i_v_sync;
  logic [3*CW-1:0]           i_bg_rgb;
  logic [N_LAYERS*3*CW-1:0]  i_layer_rgb;
  logic [N_LAYERS-1:0]       i_layer_hit;
  logic [N_LAYERS-1:0]       i_cfg_enable;
  logic [N_LAYERS-1:0]       i_cfg_blend;
  logic [CW-1:0]             o_red;
  logic [CW-1:0]             o_green;
  logic [CW-1:0]             o_blue;
  logic [COORD_W-1:0]        o_x;
  logic [COORD_W-1:0]        o_y;
  logic                      o_de;
  logic                      o_v_sync;
  logic [N_LAYERS-1:0]       o_collision;

  modport master (
    output i_x, i_y, i_de, i_v_sync, i_bg_rgb, i_layer_rgb, i_layer_hit,
           i_cfg_enable, i_cfg_blend,
    input  o_red, o_green, o_blue, o_x, o_y, o_de, o_v_sync, o_collision
  );

  modport slave (
    input  i_x, i_y, i_de, i_v_sync, i_bg_rgb, i_layer_rgb, i_layer_hit,
           i_cfg_enable, i_cfg_blend,
    output o_red, o_green, o_blue, o_x, o_y, o_de, o_v_sync, o_collision
  );
endinterface

// File: rtl/layer_mixer.sv
// rtl/layer_mixer.sv - two-stage fixed-priority sprite layer compositor
// Ports:
//   i_clk    pixel clock
//   i_rst_n  asynchronous active-low reset
//   px       layer_mixer_if.slave: pixel inputs, shadowed config, outputs
module layer_mixer #(
  parameter int N_LAYERS = 4,
  parameter int CW       = 8,
  parameter int COORD_W  = 16
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  layer_mixer_if.slave  px
);

  localparam int PW = 3 * CW;

  logic                      vs_prev_q;
  logic [N_LAYERS-1:0]       act_en_q, act_bl_q;
  logic [N_LAYERS-1:0]       coll_acc_q, coll_q;

  logic [COORD_W-1:0]        s1_x_q, s1_y_q;
  logic                      s1_de_q, s1_vs_q;
  logic [PW-1:0]             s1_bg_q;
  logic [N_LAYERS*PW-1:0]    s1_layer_q;
  logic [N_LAYERS-1:0]       s1_eh_q, s1_bl_q;

  logic [COORD_W-1:0]        s2_x_q, s2_y_q;
  logic                      s2_de_q, s2_vs_q;
  logic [PW-1:0]             s2_rgb_q;

  logic                      boundary;
  logic [N_LAYERS-1:0]       en_d, bl_d, eh_d, contrib_d;
  logic [3:0]                hit_cnt;
  logic [PW-1:0]             rgb_d;
  logic [PW-1:0]             lyr;
  logic [CW:0]               sum;

  // Rising edge of v_sync marks the frame boundary; a new config takes
  // effect on that very cycle, so the shadow values are bypassed here.
  always_comb begin
    boundary  = px.i_v_sync & ~vs_prev_q;
    en_d      = boundary ? px.i_cfg_enable : act_en_q;
    bl_d      = boundary ? px.i_cfg_blend  : act_bl_q;
    eh_d      = px.i_layer_hit & en_d;
    hit_cnt   = '0;
    for (int k = 0; k < N_LAYERS; k++) begin
      hit_cnt = hit_cnt + 4'(eh_d[k]);
    end
    contrib_d = (px.i_de && hit_cnt >= 4'd2) ? eh_d : '0;
  end

  // Bottom-up painter's algorithm; blended layers average with whatever
  // is already accumulated beneath them, so blends may chain.
  always_comb begin
    rgb_d = s1_bg_q;
    lyr   = '0;
    sum   = '0;
    for (int k = N_LAYERS - 1; k >= 0; k--) begin
      lyr = s1_layer_q[k*PW +: PW];
      if (s1_eh_q[k]) begin
        if (s1_bl_q[k]) begin
          for (int c = 0; c < 3; c++) begin
            sum = {1'b0, rgb_d[c*CW +: CW]} + {1'b0, lyr[c*CW +: CW]};
            rgb_d[c*CW +: CW] = sum[CW:1];
          end
        end else begin
          rgb_d = lyr;
        end
      end
    end
    if (!s1_de_q) begin
      rgb_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vs_prev_q  <= 1'b0;
      act_en_q   <= '1;
      act_bl_q   <= '0;
      coll_acc_q <= '0;
      coll_q     <= '0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_de_q    <= 1'b0;
      s1_vs_q    <= 1'b0;
      s1_bg_q    <= '0;
      s1_layer_q <= '0;
      s1_eh_q    <= '0;
      s1_bl_q    <= '0;
      s2_x_q     <= '0;
      s2_y_q     <= '0;
      s2_de_q    <= 1'b0;
      s2_vs_q    <= 1'b0;
      s2_rgb_q   <= '0;
    end else begin
      vs_prev_q  <= px.i_v_sync;
      act_en_q   <= en_d;
      act_bl_q   <= bl_d;
      if (boundary) begin
        coll_q     <= coll_acc_q | contrib_d;
        coll_acc_q <= '0;
      end else begin
        coll_acc_q <= coll_acc_q | contrib_d;
      end
      s1_x_q     <= px.i_x;
      s1_y_q     <= px.i_y;
      s1_de_q    <= px.i_de;
      s1_vs_q    <= px.i_v_sync;
      s1_bg_q    <= px.i_bg_rgb;
      s1_layer_q <= px.i_layer_rgb;
      s1_eh_q    <= eh_d;
      s1_bl_q    <= bl_d;
      s2_x_q     <= s1_x_q;
      s2_y_q     <= s1_y_q;
      s2_de_q    <= s1_de_q;
      s2_vs_q    <= s1_vs_q;
      s2_rgb_q   <= rgb_d;
    end
  end

  assign px.o_red       = s2_rgb_q[2*CW +: CW];
  assign px.o_green     = s2_rgb_q[CW +: CW];
  assign px.o_blue      = s2_rgb_q[0 +: CW];
  assign px.o_x         = s2_x_q;
  assign px.o_y         = s2_y_q;
  assign px.o_de        = s2_de_q;
  assign px.o_v_sync    = s2_vs_q;
  assign px.o_collision = coll_q;

endmodule

// File: tb/tb_layer_mixer.sv
// tb/tb_layer_mixer.sv - directed self-checking bench for layer_mixer
module tb_layer_mixer;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  logic [23:0] l0, l1, l2, l3;

  layer_mixer_if #(.N_LAYERS(4), .CW(8), .COORD_W(16)) ifc ();

  layer_mixer #(.N_LAYERS(4), .CW(8), .COORD_W(16)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .px      (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [23:0] bg, input logic [3:0] hit, input logic de,
                       input logic vs, input logic [15:0] x, input logic [15:0] y);
    ifc.i_bg_rgb    = bg;
    ifc.i_layer_rgb = {l3, l2, l1, l0};
    ifc.i_layer_hit = hit;
    ifc.i_de        = de;
    ifc.i_v_sync    = vs;
    ifc.i_x         = x;
    ifc.i_y         = y;
  endtask

  function automatic logic [23:0] rgb_out();
    return {ifc.o_red, ifc.o_green, ifc.o_blue};
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;
    l0 = '0; l1 = '0; l2 = '0; l3 = '0;
    ifc.i_cfg_enable = 4'b1111;
    ifc.i_cfg_blend  = 4'b0000;
    drive(24'h0, 4'b0000, 1'b0, 1'b0, 16'd0, 16'd0);
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    check("reset_rgb", rgb_out(), 24'h0);
    check("reset_de", ifc.o_de, 1'b0);
    check("reset_coll", ifc.o_collision, 4'b0000);

    // Latency and priority (enables all ones from reset, no boundary yet)
    drive(24'h102030, 4'b0000, 1'b1, 1'b0, 16'd1, 16'd1);
    tick();
    l0 = 24'hFF0000; l1 = 24'h00FF00;
    drive(24'h102030, 4'b0011, 1'b1, 1'b0, 16'd5, 16'd7);
    tick();
    check("lat_bg_rgb", rgb_out(), 24'h102030);
    check("lat_bg_x", ifc.o_x, 16'd1);
    tick();
    check("prio_rgb", rgb_out(), 24'hFF0000);
    check("prio_x", ifc.o_x, 16'd5);
    check("prio_y", ifc.o_y, 16'd7);
    check("prio_de", ifc.o_de, 1'b1);

    // Boundary B2: blend config applies to the boundary pixel itself
    l0 = 24'h000000; l1 = 24'hFE0000;
    ifc.i_cfg_blend = 4'b0011;
    drive(24'h000000, 4'b0010, 1'b1, 1'b1, 16'd10, 16'd2);
    tick();
    check("coll_prio_frame", ifc.o_collision, 4'b0011);
    tick();
    check("blend1_rgb", rgb_out(), 24'h7F0000);
    check("blend1_vs", ifc.o_v_sync, 1'b1);
    // v_sync held high: no new boundary, blend config persists
    l0 = 24'h0000FF;
    drive(24'h000000, 4'b0011, 1'b1, 1'b1, 16'd11, 16'd2);
    tick(); tick();
    check("blend2_rgb", rgb_out(), 24'h3F007F);
    // Blanking with hits present
    drive(24'h000000, 4'b1111, 1'b0, 1'b1, 16'd12, 16'd2);
    tick(); tick();
    check("blank_rgb", rgb_out(), 24'h0);
    check("blank_de", ifc.o_de, 1'b0);

    // Boundary B3: clear blend, all enabled
    drive(24'h0, 4'b0000, 1'b0, 1'b0, 16'd0, 16'd0);
    tick();
    ifc.i_cfg_blend  = 4'b0000;
    ifc.i_cfg_enable = 4'b1111;
    drive(24'h0, 4'b0000, 1'b0, 1'b1, 16'd0, 16'd0);
    tick();
    check("coll_blend_frame", ifc.o_collision, 4'b0011);
    tick();
    l0 = 24'h111111; l1 = 24'h222222; l2 = 24'h333333; l3 = 24'h444444;
    drive(24'h0, 4'b0101, 1'b1, 1'b0, 16'd3, 16'd3);
    tick(); tick();
    check("noblend_rgb", rgb_out(), 24'h111111);
    drive(24'h0, 4'b0010, 1'b1, 1'b0, 16'd4, 16'd3);
    tick(); tick();
    check("l1_alone_rgb", rgb_out(), 24'h222222);
    drive(24'h0, 4'b1111, 1'b0, 1'b0, 16'd5, 16'd3);
    tick(); tick();

    // Boundary B4: layer 2 disabled from here
    ifc.i_cfg_enable = 4'b1011;
    drive(24'h0, 4'b0000, 1'b0, 1'b1, 16'd0, 16'd0);
    tick();
    check("coll_0101", ifc.o_collision, 4'b0101);
    tick();
    drive(24'h0A0B0C, 4'b0100, 1'b1, 1'b0, 16'd6, 16'd4);
    tick(); tick();
    check("disabled_bg_rgb", rgb_out(), 24'h0A0B0C);
    drive(24'h0A0B0C, 4'b0110, 1'b1, 1'b0, 16'd7, 16'd4);
    tick(); tick();

    // Boundary B5: re-enable all
    drive(24'h0, 4'b0000, 1'b0, 1'b0, 16'd0, 16'd0);
    tick();
    ifc.i_cfg_enable = 4'b1111;
    drive(24'h0, 4'b0000, 1'b0, 1'b1, 16'd0, 16'd0);
    tick();
    check("coll_none", ifc.o_collision, 4'b0000);
    tick();
    // Mid-frame enable change is ignored
    l0 = 24'hAA0000; l1 = 24'h00BB00;
    ifc.i_cfg_enable = 4'b1110;
    drive(24'h112233, 4'b0001, 1'b1, 1'b0, 16'd8, 16'd5);
    tick(); tick();
    check("shadow_hold_rgb", rgb_out(), 24'hAA0000);

    // Boundary B6: layer 0 disabled, same-cycle effect
    drive(24'h112233, 4'b0001, 1'b1, 1'b1, 16'd9, 16'd5);
    tick(); tick();
    check("shadow_apply_bg", rgb_out(), 24'h112233);
    drive(24'h112233, 4'b0011, 1'b1, 1'b1, 16'd10, 16'd5);
    tick(); tick();
    check("shadow_apply_l1", rgb_out(), 24'h00BB00);
    drive(24'h112233, 4'b1100, 1'b1, 1'b0, 16'd11, 16'd5);
    tick(); tick();
    check("l2_over_l3_rgb", rgb_out(), 24'h333333);

    // Boundary B7
    drive(24'h0, 4'b0000, 1'b0, 1'b1, 16'd0, 16'd0);
    tick();
    check("coll_1100", ifc.o_collision, 4'b1100);
    tick();

    // Reset with full pipeline
    drive(24'h112233, 4'b0001, 1'b1, 1'b0, 16'd20, 16'd9);
    tick(); tick();
    check("pre_reset_rgb", rgb_out(), 24'h112233);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_rgb", rgb_out(), 24'h0);
    check("rst_de", ifc.o_de, 1'b0);
    check("rst_x", ifc.o_x, 16'd0);
    check("rst_coll", ifc.o_collision, 4'b0000);
    tick(); tick();
    rst_n = 1'b1;
    // Reset shadow config: all enabled, no blend; cfg changes ignored until boundary
    l0 = 24'h808080;
    ifc.i_cfg_enable = 4'b0000;
    ifc.i_cfg_blend  = 4'b1111;
    drive(24'h000000, 4'b0001, 1'b1, 1'b0, 16'd21, 16'd9);
    tick(); tick();
    check("post_reset_rgb", rgb_out(), 24'h808080);
    check("post_reset_coll", ifc.o_collision, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
